// File: rtl/branch_pkg.sv
// Shared branch definitions: RISC-V branch funct3 encodings, the counter
// reset encoding and the branch resolution rule.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Weakly-not-taken: MSB clear, every lower bit set (01 for a 2-bit counter).
  function automatic int wnt_value(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // The ALU flag means "equal"/"less than"; the negated branches invert it.
  function automatic logic resolve_taken(input logic [2:0] funct3,
                                         input logic       branch_l,
                                         input logic       is_jump);
    logic taken;
    if (is_jump) begin
      taken = 1'b1;
    end else if (funct3 == BNE || funct3 == BGE || funct3 == BGEU) begin
      taken = !branch_l;
    end else begin
      taken = branch_l;
    end
    return taken;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One branch-history entry: a saturating up/down counter whose MSB is the
// taken/not-taken prediction.
module sat_counter
  import branch_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic msb
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(wnt_value(WIDTH));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: step toward the outcome, holding at either end of the range.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; reset wins over any simultaneous update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign msb = cnt_q[WIDTH-1];

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a flop-based table of saturating counters
// indexed by PC word address, read asynchronously at fetch and trained at
// execute, plus a saturating mispredict counter.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int PC_WIDTH    = 32,
  parameter int CTR_WIDTH   = 2,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   f_pc,
  output logic                  f_pred_taken,
  input  logic                  e_valid,
  input  logic [PC_WIDTH-1:0]   e_pc,
  input  logic [2:0]            e_funct3,
  input  logic                  e_branch_l,
  input  logic                  e_is_jump,
  input  logic                  e_pred_taken,
  output logic                  e_taken,
  output logic                  e_mispredict,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [IDX-1:0]         f_idx;
  logic [IDX-1:0]         e_idx;
  logic                   upd_en;
  logic [BHT_ENTRIES-1:0] ctr_msb;
  logic [BHT_ENTRIES-1:0] ctr_inc;
  logic [BHT_ENTRIES-1:0] ctr_dec;
  logic [STAT_WIDTH-1:0]  stat_q;
  logic [STAT_WIDTH-1:0]  stat_d;
  logic                   unused_pc_bits;

  // Byte-offset and high PC bits play no part in indexing.
  assign unused_pc_bits = ^{f_pc[1:0], f_pc[PC_WIDTH-1:IDX+2],
                            e_pc[1:0], e_pc[PC_WIDTH-1:IDX+2]};

  assign f_idx = f_pc[IDX+1:2];
  assign e_idx = e_pc[IDX+1:2];

  // Resolution, flush request and training enable for the execute slot.
  always_comb begin
    e_taken      = e_valid && resolve_taken(e_funct3, e_branch_l, e_is_jump);
    e_mispredict = e_valid && (e_taken != e_pred_taken);
    upd_en       = e_valid && !e_is_jump;
  end

  // Decode the training request into per-entry inc/dec strobes.
  always_comb begin
    ctr_inc = '0;
    ctr_dec = '0;
    for (int i = 0; i < BHT_ENTRIES; i++) begin
      if (upd_en && (e_idx == IDX'(i))) begin
        ctr_inc[i] = e_taken;
        ctr_dec[i] = !e_taken;
      end
    end
  end

  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
    sat_counter #(
      .WIDTH(CTR_WIDTH)
    ) u_entry (
      .clk (clk),
      .rst (rst),
      .inc (ctr_inc[gi]),
      .dec (ctr_dec[gi]),
      .msb (ctr_msb[gi])
    );
  end

  // Fetch read sees the registered table only, so a same-cycle update is not
  // bypassed to the prediction.
  assign f_pred_taken = ctr_msb[f_idx];

  // Mispredict statistic: count flushes, sticking at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (e_mispredict && (stat_q != '1)) begin
      stat_d = stat_q + 1'b1;
    end
  end

  // Statistic register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_mispredicts = stat_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter BHT_ENTRIES, default 16, number of branch-history entries; power of two, minimum 2.
REQ-002 Parameter PC_WIDTH, default 32, program-counter width.
REQ-003 Parameter CTR_WIDTH, default 2, saturating-counter width per entry; minimum 2.
REQ-004 Parameter STAT_WIDTH, default 16, mispredict statistics counter width.
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 f_pc  input  PC_WIDTH  fetch-stage PC to predict.
REQ-008 f_pred_taken  output  1  prediction for f_pc.
REQ-009 e_valid  input  1  execute stage holds a resolved control-transfer instruction.
REQ-010 e_pc  input  PC_WIDTH  PC of the execute-stage instruction.
REQ-011 e_funct3  input  3  branch funct3 of the execute-stage instruction.
REQ-012 e_branch_l  input  1  raw comparator flag from the ALU.
REQ-013 e_is_jump  input  1  execute-stage instruction is jal/jalr.
REQ-014 e_pred_taken  input  1  prediction piped down from fetch with this instruction.
REQ-015 e_taken  output  1  resolved outcome.
REQ-016 e_mispredict  output  1  flush request to the pipeline.
REQ-017 stat_mispredicts  output  STAT_WIDTH  count of mispredicts since reset.

Function
REQ-018 Index IDX = log2(BHT_ENTRIES) bits, taken from pc[IDX+1:2]; pc[1:0] are ignored.
REQ-019 f_pred_taken SHALL be the MSB of entry[f_pc index], read combinationally with zero latency.
REQ-020 Resolution rule: e_is_jump=1 -> taken.
REQ-021 Resolution rule: funct3 in {001,101,111} -> taken = !e_branch_l.
REQ-022 Resolution rule: any other funct3 -> taken = e_branch_l.
REQ-023 e_taken SHALL equal the resolved outcome when e_valid=1 and SHALL be 0 when e_valid=0.
REQ-024 e_mispredict SHALL be e_valid && (e_taken != e_pred_taken), combinational in the same cycle.
REQ-025 When e_valid=1 and e_is_jump=0, entry[e_pc index] SHALL update at the next edge: +1 if taken, -1 if not taken.
REQ-026 Counter updates saturate: no change at all-ones when taken, no change at zero when not taken.
REQ-027 Jumps (e_is_jump=1) SHALL NOT modify the history table.
REQ-028 When f_pc and e_pc hit the same index in one cycle, f_pred_taken SHALL use the pre-update value (no bypass).
REQ-029 stat_mispredicts SHALL increment by 1 on each cycle where e_mispredict=1, and SHALL saturate at all-ones.
REQ-030 e_valid=0 SHALL leave all state unchanged.

Reset
REQ-031 When rst=1 at an edge, every history entry SHALL become weakly-not-taken (MSB 0, remaining bits 1; 01 for CTR_WIDTH=2).
REQ-032 When rst=1 at an edge, stat_mispredicts SHALL become 0.
REQ-033 Reset SHALL override a simultaneous update, including an update requested mid-operation.
REQ-034 After reset, f_pred_taken SHALL be 0 for every PC.
REQ-035 Outputs e_taken and e_mispredict are combinational and follow their inputs during reset.

Structure
REQ-036 Shared package branch_pkg SHALL hold the funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-037 branch_pkg SHALL hold the weakly-not-taken reset-encoding function of CTR_WIDTH.
REQ-038 One sub-module, sat_counter (parametrised width, with inc/dec/rst inputs), SHALL implement a single history entry.
REQ-039 branch_predict_unit SHALL instantiate BHT_ENTRIES copies of sat_counter.
REQ-040 Table storage SHALL be flops, not inferred RAM, so that reads are asynchronous.

Verification
REQ-041 Reset, then f_pc=0x100 -> f_pred_taken=0; stat_mispredicts=0.
REQ-042 Two taken beq updates (funct3=000, branch_l=1) at e_pc=0x100, then f_pc=0x100 -> f_pred_taken=1. Further updates hold the entry at 11. One not-taken update -> entry 10, prediction still 1.
REQ-043 bne, branch_l=0, e_pred_taken=0 -> e_taken=1, e_mispredict=1, stat_mispredicts increments by 1.
REQ-044 Aliasing: with BHT_ENTRIES=16, an update at e_pc=0x104 changes the prediction at f_pc=0x144. Same cycle f_pc=e_pc=0x104 -> f_pred_taken shows the old value and the new value appears next cycle.
REQ-045 jal (e_is_jump=1) with e_pred_taken=0 -> e_taken=1, e_mispredict=1, table unchanged.
REQ-046 STAT_WIDTH=4 with 20 forced mispredicts -> stat_mispredicts=15. rst asserted during an update -> entry=01 and stat_mispredicts=0 next cycle.
